fetch_sequencer: RTL

FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

---
 rtl/fetch_sequencer.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - byte-serial Y86-64 instruction fetch and decode sequencer
// Reads one instruction byte per accepted request and presents the decoded fields.
module fetch_sequencer #(
  parameter logic [63:0] RESET_PC = 64'h0
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [63:0] imem_addr,
  input  logic        imem_ack,
  input  logic [7:0]  imem_data,
  input  logic        imem_err,
  output logic [7:0]  opcode,
  output logic [3:0]  rA,
  output logic [3:0]  rB,
  output logic [63:0] valC,
  output logic [63:0] valP,
  output logic [63:0] pc,
  output logic [1:0]  stat,
  output logic        instr_valid,
  input  logic        instr_ready,
  input  logic        pc_load,
  input  logic [63:0] next_pc
);
  typedef enum logic [1:0] {FETCH, PRESENT, WAIT_PC, STOP} state_t;

  localparam logic [1:0] STAT_AOK = 2'b00;
  localparam logic [1:0] STAT_HLT = 2'b01;
  localparam logic [1:0] STAT_ADR = 2'b10;
  localparam logic [1:0] STAT_INS = 2'b11;

  state_t      r_state, w_state_next;
  logic [3:0]  r_idx, r_len;
  logic [63:0] r_pc, r_valc, r_valp;
  logic [7:0]  r_opcode;
  logic [3:0]  r_ra, r_rb;
  logic [1:0]  r_stat;

  logic        w_capture, w_valid0, w_last;
  logic [3:0]  w_len0;
  logic [2:0]  w_cpos;

  assign w_capture = imem_req && imem_ack;

  // Length and ifun legality of the byte on imem_data, read as byte 0.
  always_comb begin
    w_len0   = 4'd1;
    w_valid0 = 1'b0;
    case (imem_data[7:4])
      4'h0, 4'h1, 4'h9: begin w_len0 = 4'd1;  w_valid0 = (imem_data[3:0] == 4'h0); end
      4'h2:             begin w_len0 = 4'd2;  w_valid0 = (imem_data[3:0] <= 4'h6); end
      4'h3, 4'h4, 4'h5: begin w_len0 = 4'd10; w_valid0 = (imem_data[3:0] == 4'h0); end
      4'h6:             begin w_len0 = 4'd2;  w_valid0 = (imem_data[3:0] <= 4'h3); end
      4'h7:             begin w_len0 = 4'd9;  w_valid0 = (imem_data[3:0] <= 4'h6); end
      4'h8:             begin w_len0 = 4'd9;  w_valid0 = (imem_data[3:0] == 4'h0); end
      4'hA, 4'hB:       begin w_len0 = 4'd2;  w_valid0 = (imem_data[3:0] == 4'h0); end
      default:          begin w_len0 = 4'd1;  w_valid0 = 1'b0; end
    endcase
  end

  assign w_last = (r_idx == 4'd0) ? (!w_valid0 || (w_len0 == 4'd1))
                                  : (r_idx == (r_len - 4'd1));
  // The constant starts at byte 1 for 9-byte formats, byte 2 for 10-byte formats.
  assign w_cpos = (r_len == 4'd9) ? 3'(r_idx - 4'd1) : 3'(r_idx - 4'd2);

  always_ff @(posedge clk) begin
    if (reset) r_state <= FETCH;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      FETCH:   if (w_capture && (imem_err || w_last)) w_state_next = PRESENT;
      PRESENT: if (instr_ready) w_state_next = (r_stat == STAT_AOK) ? WAIT_PC : STOP;
      WAIT_PC: if (pc_load) w_state_next = FETCH;
      default: w_state_next = r_state;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc     <= RESET_PC;
      r_idx    <= 4'd0;
      r_len    <= 4'd1;
      r_stat   <= STAT_AOK;
      r_opcode <= 8'h00;
      r_ra     <= 4'hF;
      r_rb     <= 4'hF;
      r_valc   <= 64'h0;
      r_valp   <= 64'h0;
    end else begin
      case (r_state)
        FETCH: begin
          if (w_capture) begin
            if (imem_err) begin
              r_stat <= STAT_ADR;
            end else if (r_idx == 4'd0) begin
              r_opcode <= imem_data;
              r_len    <= w_len0;
              r_idx    <= 4'd1;
              if (!w_valid0) begin
                r_stat <= STAT_INS;
                r_valp <= r_pc + 64'd1;
              end else begin
                r_valp <= r_pc + {60'h0, w_len0};
                if (imem_data == 8'h00) r_stat <= STAT_HLT;
              end
            end else begin
              r_idx <= r_idx + 4'd1;
              if ((r_idx == 4'd1) && (r_len != 4'd9)) begin
                r_ra <= imem_data[7:4];
                r_rb <= imem_data[3:0];
              end else begin
                r_valc[{w_cpos, 3'b000} +: 8] <= imem_data;
              end
            end
          end
        end
        WAIT_PC: begin
          if (pc_load) begin
            r_pc     <= next_pc;
            r_idx    <= 4'd0;
            r_len    <= 4'd1;
            r_stat   <= STAT_AOK;
            r_opcode <= 8'h00;
            r_ra     <= 4'hF;
            r_rb     <= 4'hF;
            r_valc   <= 64'h0;
            r_valp   <= 64'h0;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign imem_req    = (r_state == FETCH) && !reset;
  assign imem_addr   = r_pc + {60'h0, r_idx};
  assign instr_valid = (r_state == PRESENT);
  assign opcode      = r_opcode;
  assign rA          = r_ra;
  assign rB          = r_rb;
  assign valC        = r_valc;
  assign valP        = r_valp;
  assign pc          = r_pc;
  assign stat        = r_stat;
endmodule
